// File: rtl/column_sort_pkg.sv
// Shared types and constants for the column_sort sequencer.
package column_sort_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int PAD_VAL    = 0;

endpackage

// File: rtl/column_sort_addr_gen.sv
// Column/row/slot counters and row selection for the 3-tap vertical fetch; combinational issue, one read per cycle.
// pause only holds at slot 0; COLUMN_SORT_CTRL_CLAMP_EN selects edge clamping instead of zero padding.
module column_sort_addr_gen #(
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int ADDR_W = $clog2(IMG_W*IMG_H)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     active,
    input  logic                     pause,
    output logic                     issue,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    output logic                     pad,
    output logic                     tag_vld,
    output logic [$clog2(IMG_W)-1:0] tag_x,
    output logic [$clog2(IMG_H)-1:0] tag_y,
    output logic                     last
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_MAX = XW'(IMG_W-1);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H-1);

    logic [1:0]    slot;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          oor;
    int            row;

    always_comb begin
        issue = active && !((slot == 2'd0) && pause);
        oor   = ((slot == 2'd0) && (y == '0)) || ((slot == 2'd2) && (y == Y_MAX));
        row   = int'(y) + int'(slot) - 1;
        // Out-of-range rows fall back to the centre row, which is also the clamp target.
        if (oor) begin
            row = int'(y);
        end
`ifdef COLUMN_SORT_CTRL_CLAMP_EN
        rd_en = issue;
        pad   = 1'b0;
`else
        rd_en = issue && !oor;
        pad   = issue && oor;
`endif
        rd_addr = rd_en ? ADDR_W'(row * IMG_W + int'(x)) : '0;
        tag_vld = issue && (slot == 2'd2);
        tag_x   = x;
        tag_y   = y;
        last    = tag_vld && (x == X_MAX) && (y == Y_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            slot <= 2'd0;
            x    <= '0;
            y    <= '0;
        end else if (issue) begin
            if (slot == 2'd2) begin
                slot <= 2'd0;
                if (x == X_MAX) begin
                    x <= '0;
                    y <= (y == Y_MAX) ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end else begin
                slot <= slot + 2'd1;
            end
        end
    end

endmodule

// File: rtl/column_sort_ctrl.sv
// Frame sequencer feeding column_sort: 3 reads per column, col_valid 1+SORT_LAT cycles after the third read.
// pause stalls only at column boundaries; build with COLUMN_SORT_CTRL_CLAMP_EN for edge clamping, else zero padding.
module column_sort_ctrl
    import column_sort_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int IMG_W    = 16,
    parameter int IMG_H    = 16,
    parameter int SORT_LAT = 1,
    parameter int ADDR_W   = $clog2(IMG_W*IMG_H)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     pause,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic [DATA_W-1:0]        rd_data,
    output logic [DATA_W-1:0]        sort_a,
    output logic                     sort_load,
    output logic                     col_valid,
    output logic [$clog2(IMG_W)-1:0] col_x,
    output logic [$clog2(IMG_H)-1:0] col_y
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    state_t        state, state_nxt;
    logic          issue, pad, tag_vld, last;
    logic [XW-1:0] tag_x;
    logic [YW-1:0] tag_y;
    logic          pad_q;
    logic          vld_pipe [SORT_LAT+1];
    logic [XW-1:0] x_pipe   [SORT_LAT+1];
    logic [YW-1:0] y_pipe   [SORT_LAT+1];

    column_sort_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == IDLE),
        .active  (state == FETCH),
        .pause   (pause),
        .issue   (issue),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .pad     (pad),
        .tag_vld (tag_vld),
        .tag_x   (tag_x),
        .tag_y   (tag_y),
        .last    (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = FETCH;
            FETCH: if (last) state_nxt = DRAIN;
            // Tag identifies the final column, so earlier valids still in flight cannot end the drain.
            DRAIN: if (col_valid && (col_x == XW'(IMG_W-1)) && (col_y == YW'(IMG_H-1)))
                       state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        busy = (state == FETCH) || (state == DRAIN);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sort_load <= 1'b0;
            pad_q     <= 1'b0;
            for (int i = 0; i <= SORT_LAT; i++) begin
                vld_pipe[i] <= 1'b0;
                x_pipe[i]   <= '0;
                y_pipe[i]   <= '0;
            end
        end else begin
            sort_load   <= issue;
            pad_q       <= pad;
            vld_pipe[0] <= tag_vld;
            x_pipe[0]   <= tag_x;
            y_pipe[0]   <= tag_y;
            for (int i = 1; i <= SORT_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                x_pipe[i]   <= x_pipe[i-1];
                y_pipe[i]   <= y_pipe[i-1];
            end
        end
    end

    always_comb begin
        sort_a    = (sort_load && !pad_q) ? rd_data : DATA_W'(PAD_VAL);
        col_valid = vld_pipe[SORT_LAT];
        col_x     = x_pipe[SORT_LAT];
        col_y     = y_pipe[SORT_LAT];
    end

endmodule

// File: tb/tb_column_sort_ctrl.sv
// Bench for column_sort_ctrl: per-cycle schedule derived from the pause table and the column fetch rules.
module tb_column_sort_ctrl;

    localparam int DW   = 8;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int SL   = 1;
    localparam int AW   = $clog2(W*H);
    localparam int NC   = W*H;
    localparam int MAXC = 256;

    logic          clk, rst, start, pause;
    logic          busy, done, rd_en, sort_load, col_valid;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data, sort_a;
    logic [$clog2(W)-1:0] col_x;
    logic [$clog2(H)-1:0] col_y;
    logic [DW-1:0] mem [NC];

    column_sort_ctrl #(
        .DATA_W   (DW),
        .IMG_W    (W),
        .IMG_H    (H),
        .SORT_LAT (SL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pause     (pause),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .sort_a    (sort_a),
        .sort_load (sort_load),
        .col_valid (col_valid),
        .col_x     (col_x),
        .col_y     (col_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    bit ptab   [MAXC];
    bit e_en   [MAXC];
    int e_addr [MAXC];
    bit e_load [MAXC];
    int e_a    [MAXC];
    bit e_cv   [MAXC];
    int e_cx   [MAXC];
    int e_cy   [MAXC];
    bit e_busy [MAXC];
    bit e_done [MAXC];
    int done_cyc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Column k = raster position; it starts at the first boundary cycle whose pause is low.
    function automatic void build_model();
        int b, s, x, y, r, v, last_cv;
        bit oor, en;
        for (int c = 0; c < MAXC; c++) begin
            e_en[c] = 0; e_addr[c] = 0; e_load[c] = 0; e_a[c] = 0;
            e_cv[c] = 0; e_cx[c] = 0; e_cy[c] = 0; e_busy[c] = 0; e_done[c] = 0;
        end
        b = 1;
        last_cv = 0;
        for (int k = 0; k < NC; k++) begin
            x = k % W;
            y = k / W;
            while (ptab[b]) b++;
            s = b;
            for (int j = 0; j < 3; j++) begin
                r   = y + j - 1;
                oor = (r < 0) || (r >= H);
                if (r < 0) r = 0;
                if (r >= H) r = H - 1;
`ifdef COLUMN_SORT_CTRL_CLAMP_EN
                en = 1;
                v  = r * W + x;
`else
                en = !oor;
                v  = oor ? 0 : r * W + x;
`endif
                e_en[s+j]     = en;
                e_addr[s+j]   = r * W + x;
                e_load[s+j+1] = 1;
                e_a[s+j+1]    = v;
            end
            e_cv[s+3+SL] = 1;
            e_cx[s+3+SL] = x;
            e_cy[s+3+SL] = y;
            last_cv      = s + 3 + SL;
            b            = s + 3;
        end
        done_cyc = last_cv + 1;
        e_done[done_cyc] = 1;
        for (int c = 1; c < done_cyc; c++) e_busy[c] = 1;
    endfunction

    task automatic compare_cycle(input int c);
        check_val("busy", 32'(busy), 32'(e_busy[c]));
        check_val("done", 32'(done), 32'(e_done[c]));
        check_val("rd_en", 32'(rd_en), 32'(e_en[c]));
        if (e_en[c]) check_val("rd_addr", 32'(rd_addr), 32'(e_addr[c]));
        check_val("sort_load", 32'(sort_load), 32'(e_load[c]));
        if (e_load[c]) check_val("sort_a", 32'(sort_a), 32'(e_a[c]));
        check_val("col_valid", 32'(col_valid), 32'(e_cv[c]));
        if (e_cv[c]) begin
            check_val("col_x", 32'(col_x), 32'(e_cx[c]));
            check_val("col_y", 32'(col_y), 32'(e_cy[c]));
        end
    endtask

    // stop_at < 0 runs the whole frame; otherwise the frame is aborted by reset after stop_at cycles.
    task automatic run_frame(input int stop_at);
        int n;
        build_model();
        n = (stop_at < 0) ? done_cyc + 3 : stop_at;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            cyc   = c;
            start = (c == 0) ? 1'b1 : ((c <= done_cyc) ? 1'($urandom_range(0, 1)) : 1'b0);
            pause = ptab[c];
            @(negedge clk);
            compare_cycle(c);
        end
        start = 1'b0;
        pause = 1'b0;
        if (stop_at >= 0) begin
            @(posedge clk);
            #1;
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            check_val("abort_busy", 32'(busy), 32'd0);
            check_val("abort_col_valid", 32'(col_valid), 32'd0);
            check_val("abort_rd_en", 32'(rd_en), 32'd0);
            check_val("abort_sort_load", 32'(sort_load), 32'd0);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_done"}, 32'(done), 32'd0);
        check_val({tag, "_rd_en"}, 32'(rd_en), 32'd0);
        check_val({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        check_val({tag, "_sort_load"}, 32'(sort_load), 32'd0);
        check_val({tag, "_sort_a"}, 32'(sort_a), 32'd0);
        check_val({tag, "_col_valid"}, 32'(col_valid), 32'd0);
        check_val({tag, "_col_xy"}, 32'({col_x, col_y}), 32'd0);
    endtask

    task automatic random_pauses();
        for (int c = 0; c < MAXC; c++) ptab[c] = (c < 150) && ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        for (int i = 0; i < NC; i++) mem[i] = DW'(i);
        rst   = 1'b1;
        start = 1'b1;
        pause = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check_idle_zero("reset");
        end
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_idle_zero("post_reset");

        for (int c = 0; c < MAXC; c++) ptab[c] = 0;
        run_frame(-1);

        // Two-cycle hold at the column-3 boundary plus pauses inside columns that must be ignored.
        for (int c = 0; c < MAXC; c++) ptab[c] = 0;
        ptab[6]  = 1;
        ptab[10] = 1;
        ptab[11] = 1;
        ptab[14] = 1;
        run_frame(-1);

        random_pauses();
        run_frame(14);

        for (int f = 0; f < 3; f++) begin
            random_pauses();
            run_frame(-1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
